// File: rtl/wifi_phy_pkg.sv
// Shared WiFi PHY constants and types for the 64-point OFDM subcarrier mapper/demapper.
package wifi_phy_pkg;

  localparam int unsigned N_FFT   = 64;
  localparam int unsigned N_DATA  = 48;
  localparam int unsigned N_PILOT = 4;
  localparam int unsigned IDX_W   = 6;

  // Pilot positions in IFFT natural order; slot order follows frequency -21, -7, +7, +21.
  localparam logic [IDX_W-1:0] PILOT_IDX_S0 = 6'd43;
  localparam logic [IDX_W-1:0] PILOT_IDX_S1 = 6'd57;
  localparam logic [IDX_W-1:0] PILOT_IDX_S2 = 6'd7;
  localparam logic [IDX_W-1:0] PILOT_IDX_S3 = 6'd21;

  localparam logic [IDX_W-1:0] NULL_LO = 6'd27;
  localparam logic [IDX_W-1:0] NULL_HI = 6'd37;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PFETCH,
    ST_MAP
  } map_state_t;

  typedef enum logic [1:0] {
    SC_NULL,
    SC_PILOT,
    SC_DATA
  } sc_class_t;

endpackage

// File: rtl/wifi_subcarrier_classifier.sv
// Combinational subcarrier classifier: IFFT index -> null / pilot / data plus pilot slot.
module wifi_subcarrier_classifier
  import wifi_phy_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output sc_class_t        sc_class,
  output logic [1:0]       pilot_slot
);

  always_comb begin
    sc_class   = SC_DATA;
    pilot_slot = 2'd0;
    if ((idx == '0) || ((idx >= NULL_LO) && (idx <= NULL_HI))) begin
      sc_class = SC_NULL;
    end else begin
      case (idx)
        PILOT_IDX_S0: begin sc_class = SC_PILOT; pilot_slot = 2'd0; end
        PILOT_IDX_S1: begin sc_class = SC_PILOT; pilot_slot = 2'd1; end
        PILOT_IDX_S2: begin sc_class = SC_PILOT; pilot_slot = 2'd2; end
        PILOT_IDX_S3: begin sc_class = SC_PILOT; pilot_slot = 2'd3; end
        default:      sc_class = SC_DATA;
      endcase
    end
  end

endmodule

// File: rtl/wifi_pilot_subcarrier_mapper.sv
// Assembles one 64-subcarrier OFDM frame per symbol from 4 fetched pilots and 48 mapper samples.
module wifi_pilot_subcarrier_mapper
  import wifi_phy_pkg::*;
#(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in_re,
  input  logic [WIDTH-1:0] data_in_im,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [WIDTH-1:0] pilot_in,
  input  logic             pilot_valid,
  output logic             pilot_en,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic             out_valid,
  output logic             out_sos,
  output logic             out_eos,
  output logic             pilot_overrun
);

  map_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [2:0]       en_cnt;
  logic [2:0]       pcnt;
  logic [WIDTH-1:0] pilot_buf [N_PILOT];

  sc_class_t        cur_class;
  logic [1:0]       cur_slot;
  logic             advance;

  wifi_subcarrier_classifier u_classifier (
    .idx        (idx),
    .sc_class   (cur_class),
    .pilot_slot (cur_slot)
  );

  assign data_ready = (state == ST_MAP) && (cur_class == SC_DATA);
  assign advance    = (cur_class != SC_DATA) || data_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      idx           <= '0;
      en_cnt        <= '0;
      pcnt          <= '0;
      pilot_en      <= 1'b0;
      out_re        <= '0;
      out_im        <= '0;
      out_valid     <= 1'b0;
      out_sos       <= 1'b0;
      out_eos       <= 1'b0;
      pilot_overrun <= 1'b0;
      for (int unsigned i = 0; i < N_PILOT; i++) begin
        pilot_buf[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      out_sos   <= 1'b0;
      out_eos   <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;

      case (state)
        ST_IDLE: begin
          pilot_en <= 1'b0;
          if (enable) begin
            state    <= ST_PFETCH;
            pilot_en <= 1'b1;
            en_cnt   <= '0;
            pcnt     <= '0;
          end
        end

        ST_PFETCH: begin
          // pilot_en was raised on entry; drop it after the 4th high cycle (en_cnt == 3).
          if (en_cnt < 3'd4) begin
            en_cnt <= en_cnt + 3'd1;
          end
          pilot_en <= (en_cnt < 3'd3);

          if (pilot_valid) begin
            if (pcnt < 3'd4) begin
              pilot_buf[pcnt[1:0]] <= pilot_in;
              pcnt                 <= pcnt + 3'd1;
            end else begin
              pilot_overrun <= 1'b1;
            end
          end

          if ((pcnt == 3'd4) && (en_cnt == 3'd4)) begin
            state <= ST_MAP;
            idx   <= '0;
          end
        end

        ST_MAP: begin
          if (advance) begin
            out_valid <= 1'b1;
            out_sos   <= (idx == '0);
            out_eos   <= (idx == '1);
            case (cur_class)
              SC_PILOT: out_re <= pilot_buf[cur_slot];
              SC_DATA: begin
                out_re <= data_in_re;
                out_im <= data_in_im;
              end
              default: ;
            endcase
            idx <= idx + 6'd1;

            // enable is only honoured at the symbol boundary, so frames are never truncated.
            if (idx == '1) begin
              if (enable) begin
                state    <= ST_PFETCH;
                pilot_en <= 1'b1;
                en_cnt   <= '0;
                pcnt     <= '0;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/wifi_pilot_subcarrier_mapper.md
Name: wifi_pilot_subcarrier_mapper

Overview:
- Sits between the WiFi constellation mapper / pilot generator and the 64-point IFFT.
- Per OFDM symbol it collects 4 pilot values from the pilot generator and 48 modulated data samples from the mapper.
- It emits one 64-subcarrier frame in IFFT natural order (k=0..31 then k=-32..-1), with nulls at DC and the guard band.
- It owns the pilot generator's enable, fetching exactly 4 pilots per symbol.

Parameters:
- WIDTH, 12, bit width of each I/Q component and of the pilot value (signed two's complement).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request; sampled only at symbol boundaries.
- data_in_re  in  WIDTH  data subcarrier, real part.
- data_in_im  in  WIDTH  data subcarrier, imaginary part.
- data_valid  in  1  data_in_* valid.
- data_ready  out  1  mapper consumes data_in_* when data_valid && data_ready.
- pilot_in  in  WIDTH  pilot value, real only; +1 = 12'h200, -1 = 12'hE00.
- pilot_valid  in  1  pilot_in valid.
- pilot_en  out  1  enable to the pilot generator.
- out_re  out  WIDTH  subcarrier real part to the IFFT.
- out_im  out  WIDTH  subcarrier imaginary part to the IFFT.
- out_valid  out  1  out_* valid.
- out_sos  out  1  start of symbol; high with out_valid at k=0.
- out_eos  out  1  end of symbol; high with out_valid at index 63.
- pilot_overrun  out  1  sticky error flag.

Behaviour:
- Reset (async, active-low): state=IDLE. All outputs 0: data_ready, pilot_en, out_re, out_im, out_valid, out_sos, out_eos, pilot_overrun. Pilot buffer and pilot counter cleared; subcarrier index idx=0.

- FSM states: IDLE, PFETCH, MAP.
  - IDLE: if enable=1, go to PFETCH next cycle.
  - PFETCH:
    - pilot_en=1 for exactly 4 consecutive cycles from state entry (en_cnt 0..3), then 0.
    - Each pilot_valid writes pilot_in into slot[pcnt]; pcnt increments, saturating at 4.
    - A pilot_valid arriving with pcnt=4 is discarded and sets pilot_overrun (cleared only by reset).
    - When pcnt=4 and en_cnt has expired, go to MAP with idx=0.
  - MAP: walks idx 0..63; one output per advancing cycle. Each idx is classified as:
    - Null: idx 0 and 27..37. Output 0+j0. Advances unconditionally.
    - Pilot:
      - idx 7 outputs slot2 (+7).
      - idx 21 outputs slot3 (+21).
      - idx 43 outputs slot0 (-21).
      - idx 57 outputs slot1 (-7).
      - Imaginary part is 0. Advances unconditionally.
    - Data: all other indices (48 in total).
      - data_ready=1 combinationally.
      - On data_valid: output data_in_re/im and advance.
      - If data_valid=0: stall. idx holds, out_valid=0 that cycle.
  - At the end of MAP (idx=63 output): if enable=1 go to PFETCH and clear pcnt; else go to IDLE.
- Latency: outputs registered; out_* appear 1 cycle after the idx/handshake cycle. data_ready is low outside MAP data indices.
- Symbol time: unstalled, 64 output cycles plus ≥5 cycles of PFETCH between symbols. out_valid is low during PFETCH.
- enable deasserted mid-symbol: the current symbol completes in full; partial frames are never emitted.
- Reset asserted mid-symbol: immediate abort; no further out_valid until a new symbol.
- Pilots arriving late (after en_cnt expired but pcnt<4): keep waiting in PFETCH; no timeout.
- Exactly 48 data handshakes occur per symbol.

Decomposition:
- Shared package / header, wifi_phy_pkg:
  - N_FFT=64, N_DATA=48, N_PILOT=4.
  - Pilot index constants (7, 21, 43, 57).
  - Null band bounds (27, 37).
  - FSM state encodings.
- Sub-module wifi_subcarrier_classifier: combinational idx → {NULL, PILOT, DATA} plus pilot slot select. Reused by the RX demapper.

Test Plan:
- Pilot ordering: pilots 12'h200, 12'h200, 12'h200, 12'hE00 (arrival order), data_valid held 1 with incrementing re=1..48, im=0.
  - Required: idx 7=12'h200, 21=12'hE00, 43=12'h200, 57=12'h200.
  - Data re=1..48 at the non-null, non-pilot indices in ascending idx order.
  - idx 0 and 27..37 output 0.
  - out_sos at idx0, out_eos at idx63.
- Data stalls: data_valid toggled 1,0,1,0 throughout the symbol. Required: out_valid pulses=64 total, data order preserved, each pilot/null emitted once, symbol still ends with out_eos.
- Pilot overrun: 5 pilot_valid pulses during PFETCH. Required: pilot_overrun=1 and remains 1; first 4 pilots used.
- Enable drop mid-symbol: enable falls at idx 20. Required: remaining 44 outputs emitted, then IDLE; pilot_en stays 0 afterwards.
- Back-to-back symbols: enable held 1 for 3 symbols. Required: exactly 12 pilot_en-high cycles, 144 data handshakes, 3 out_sos/out_eos pairs.
- Reset mid-MAP: reset asserted at idx 30. Required: all outputs 0 in the same cycle. After release with enable=1, PFETCH restarts and the next out_sos is at idx0.
